// File: rtl/matrix_scroll_param.sv
// Scrolling LED-matrix driver: a run-time writable DEPTH-row pattern buffer,
// a ROWS-row scan window, and a paused/bidirectional step timer moving it.
module matrix_scroll_param #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int DEPTH    = 16,
  parameter int SCAN_DIV = 8192,
  parameter int STEP_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     dir,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [COLS-1:0]          wr_data,
  output logic [COLS-1:0]          segout,
  output logic [$clog2(ROWS)-1:0]  scanout,
  output logic [$clog2(DEPTH)-1:0] offset,
  output logic                     step_tick
);

  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int TW = $clog2(STEP_DIV);

  logic [COLS-1:0] pat_r [DEPTH];
  logic [SW-1:0]   scan_cnt_r;
  logic [SW-1:0]   scan_cnt_s;
  logic [TW-1:0]   step_cnt_r;
  logic [TW-1:0]   step_cnt_s;
  logic            scan_wrap_s;
  logic            step_wrap_s;
  logic [RW-1:0]   scan_s;
  logic [AW-1:0]   offset_s;
  logic [AW-1:0]   rd_idx_s;

  // Next-state for counters, window position and buffer read index
  always_comb begin
    scan_wrap_s = (scan_cnt_r == SW'(SCAN_DIV - 1));
    step_wrap_s = en && (step_cnt_r == TW'(STEP_DIV - 1));

    if (scan_wrap_s) begin
      scan_cnt_s = '0;
      scan_s     = scanout + RW'(1);
    end else begin
      scan_cnt_s = scan_cnt_r + SW'(1);
      scan_s     = scanout;
    end

    if (!en) begin
      step_cnt_s = step_cnt_r;
    end else if (step_wrap_s) begin
      step_cnt_s = '0;
    end else begin
      step_cnt_s = step_cnt_r + TW'(1);
    end

    if (step_wrap_s) begin
      if (dir) begin
        offset_s = offset - AW'(1);
      end else begin
        offset_s = offset + AW'(1);
      end
    end else begin
      offset_s = offset;
    end

    // Read with the values being loaded this edge so segout never lags a row change
    rd_idx_s = offset_s + AW'(scan_s);
  end

  // Pattern buffer: blanked on reset, host-written otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat_r[i] <= '1;
      end
    end else if (wr_en) begin
      pat_r[wr_addr] <= wr_data;
    end
  end

  // Counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_r <= '0;
      step_cnt_r <= '0;
      scanout    <= '0;
      offset     <= '0;
      step_tick  <= 1'b0;
      segout     <= '1;
    end else begin
      scan_cnt_r <= scan_cnt_s;
      step_cnt_r <= step_cnt_s;
      scanout    <= scan_s;
      offset     <= offset_s;
      step_tick  <= step_wrap_s;
      segout     <= pat_r[rd_idx_s];
    end
  end

endmodule

// File: tb/tb_matrix_scroll_param.sv
// Self-checking bench for matrix_scroll_param: directed scenarios plus random
// traffic, all compared against an arithmetic model driven by elapsed edge counts.
module tb_matrix_scroll_param;

  localparam int ROWS = 4, COLS = 8, DEPTH = 8, SCAN_DIV = 4, STEP_DIV = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, dir, wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] segout;
  logic [1:0] scanout;
  logic [2:0] offset;
  logic       step_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: position derives from edges since reset (t) and enabled edges (e)
  int         t, e, off_m, scan_m;
  logic       tick_m;
  logic [7:0] seg_m;
  logic [7:0] buf_m [DEPTH];

  matrix_scroll_param #(
    .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV), .STEP_DIV(STEP_DIV)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .segout(segout),
    .scanout(scanout), .offset(offset), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  function automatic void reset_model();
    t = 0; e = 0; off_m = 0; scan_m = 0; tick_m = 1'b0; seg_m = 8'hFF;
    for (int i = 0; i < DEPTH; i++) buf_m[i] = 8'hFF;
  endfunction

  function automatic void model_edge();
    if (reset) begin
      reset_model();
    end else begin
      t++;
      scan_m = (t / SCAN_DIV) % ROWS;
      tick_m = 1'b0;
      if (en) begin
        e++;
        if (e % STEP_DIV == 0) begin
          tick_m = 1'b1;
          off_m  = dir ? (off_m + DEPTH - 1) % DEPTH : (off_m + 1) % DEPTH;
        end
      end
      seg_m = buf_m[(off_m + scan_m) % DEPTH];
      if (wr_en) buf_m[wr_addr] = wr_data;
    end
  endfunction

  task automatic step_clk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic fill_ramp();
    en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(i);
      step_clk();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({segout, scanout, offset, step_tick} !== {8'hFF, 2'd0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got seg=%h scan=%0d off=%0d tick=%b, expected seg=ff scan=0 off=0 tick=0",
               segout, scanout, offset, step_tick);
    end
    @(negedge clk);
    reset = 1'b0;
    reset_model();
  endtask

  task automatic test_scan();
    fill_ramp();
    for (int k = 0; k < 24; k++) begin
      step_clk();
      n_checks++;
      if ({segout, scanout, offset, step_tick} !== {seg_m, 2'(scan_m), 3'(off_m), tick_m} ||
          segout !== 8'(scanout) || offset !== 3'd0) begin
        n_fail++;
        $display("FAIL scan: got seg=%h scan=%0d off=%0d tick=%b, expected seg=%h scan=%0d off=0 tick=%b",
                 segout, scanout, offset, step_tick, seg_m, scan_m, tick_m);
      end
    end
  endtask

  task automatic test_forward();
    int ticks = 0;
    en = 1'b1; dir = 1'b0;
    for (int k = 0; k < 100 && off_m != 6; k++) begin
      step_clk();
      if (step_tick) ticks++;
      n_checks++;
      if ({segout, scanout, offset, step_tick} !== {seg_m, 2'(scan_m), 3'(off_m), tick_m}) begin
        n_fail++;
        $display("FAIL forward: got seg=%h scan=%0d off=%0d tick=%b, expected seg=%h scan=%0d off=%0d tick=%b",
                 segout, scanout, offset, step_tick, seg_m, scan_m, off_m, tick_m);
      end
    end
    n_checks++;
    if (offset !== 3'd6 || ticks != 6) begin
      n_fail++;
      $display("FAIL forward_reach6: got off=%0d ticks=%0d, expected off=6 ticks=6", offset, ticks);
    end
    en = 1'b0;
    for (int k = 0; k < 20 && scanout !== 2'd3; k++) step_clk();
    n_checks++;
    if ({scanout, offset, segout} !== {2'd3, 3'd6, 8'h01}) begin
      n_fail++;
      $display("FAIL forward_window: got scan=%0d off=%0d seg=%h, expected scan=3 off=6 seg=01",
               scanout, offset, segout);
    end
    en = 1'b1;
    for (int k = 0; k < 40 && !(step_tick && offset == 3'd0); k++) step_clk();
    n_checks++;
    if (offset !== 3'd0 || step_tick !== 1'b1 || off_m != 0) begin
      n_fail++;
      $display("FAIL forward_wrap: got off=%0d tick=%b, expected off=0 tick=1", offset, step_tick);
    end
  endtask

  task automatic test_reverse();
    int edges = 0;
    do_reset();
    fill_ramp();
    en = 1'b1; dir = 1'b1;
    for (int k = 0; k < 15 && step_tick !== 1'b1; k++) begin
      step_clk();
      edges++;
    end
    n_checks++;
    if (offset !== 3'd7 || edges != STEP_DIV) begin
      n_fail++;
      $display("FAIL reverse_first: got off=%0d after %0d edges, expected off=7 after 10 edges", offset, edges);
    end
    en = 1'b0;
    for (int k = 0; k < 20 && scanout !== 2'd1; k++) step_clk();
    n_checks++;
    if ({scanout, offset, segout} !== {2'd1, 3'd7, 8'h00}) begin
      n_fail++;
      $display("FAIL reverse_window: got scan=%0d off=%0d seg=%h, expected scan=1 off=7 seg=00",
               scanout, offset, segout);
    end
  endtask

  task automatic test_pause();
    logic [2:0] held;
    en = 1'b1; dir = 1'b0;
    for (int k = 0; k < 20 && (e % STEP_DIV) != 6; k++) step_clk();
    held = offset;
    en = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step_clk();
      n_checks++;
      if (offset !== held || step_tick !== 1'b0 || offset !== 3'(off_m)) begin
        n_fail++;
        $display("FAIL pause_hold: got off=%0d tick=%b, expected off=%0d tick=0", offset, step_tick, held);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step_clk();
      n_checks++;
      if (step_tick !== (k == 4) || step_tick !== tick_m) begin
        n_fail++;
        $display("FAIL pause_resume: edge %0d got tick=%b, expected tick=%b", k, step_tick, (k == 4));
      end
    end
    n_checks++;
    if (offset !== 3'(held + 3'd1)) begin
      n_fail++;
      $display("FAIL pause_step: got off=%0d, expected off=%0d", offset, 3'(held + 3'd1));
    end
  endtask

  task automatic test_write_hazard();
    do_reset();
    fill_ramp();
    for (int k = 0; k < 40 && !(scanout == 2'd2 && (t % SCAN_DIV) <= 1); k++) step_clk();
    n_checks++;
    if (segout !== 8'h02 || scanout !== 2'd2) begin
      n_fail++;
      $display("FAIL hazard_setup: got scan=%0d seg=%h, expected scan=2 seg=02", scanout, segout);
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hA5;
    step_clk();
    wr_en = 1'b0;
    n_checks++;
    if (segout !== 8'h02 || segout !== seg_m) begin
      n_fail++;
      $display("FAIL hazard_old: got seg=%h, expected seg=02", segout);
    end
    step_clk();
    n_checks++;
    if (segout !== 8'hA5 || scanout !== 2'd2) begin
      n_fail++;
      $display("FAIL hazard_new: got scan=%0d seg=%h, expected scan=2 seg=a5", scanout, segout);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en      = ($urandom_range(0, 3) != 0);
      dir     = $urandom_range(0, 1) == 1;
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 3'($urandom_range(0, DEPTH - 1));
      wr_data = 8'($urandom);
      step_clk();
      n_checks++;
      if ({segout, scanout, offset, step_tick} !== {seg_m, 2'(scan_m), 3'(off_m), tick_m}) begin
        n_fail++;
        $display("FAIL random: cycle %0d got seg=%h scan=%0d off=%0d tick=%b, expected seg=%h scan=%0d off=%0d tick=%b",
                 k, segout, scanout, offset, step_tick, seg_m, scan_m, off_m, tick_m);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] seen = 4'b0000;
    en = 1'b1; dir = 1'b0;
    for (int k = 0; k < 23; k++) step_clk();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    reset_model();
    n_checks++;
    if ({segout, scanout, offset, step_tick} !== {8'hFF, 2'd0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: got seg=%h scan=%0d off=%0d tick=%b, expected seg=ff scan=0 off=0 tick=0",
               segout, scanout, offset, step_tick);
    end
    @(negedge clk);
    step_clk();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step_clk();
      seen[scanout] = 1'b1;
      n_checks++;
      if (segout !== 8'hFF || scanout !== 2'(scan_m)) begin
        n_fail++;
        $display("FAIL reset_blank: got seg=%h scan=%0d, expected seg=ff scan=%0d", segout, scanout, scan_m);
      end
    end
    n_checks++;
    if (seen !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_rows: got rows seen=%b, expected 1111", seen);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    reset_model();
    test_reset();
    test_scan();
    test_forward();
    test_reverse();
    test_pause();
    test_write_hazard();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_scroll_param.md
# matrix_scroll_param

Parametrised scrolling LED-matrix driver. It holds a DEPTH-row pattern buffer that the host writes at run time. It time-multiplexes a ROWS-row window of that buffer onto the matrix row-select (`scanout`) and column-data (`segout`) pins. A programmable step timer scrolls the window forward or backward through the buffer with wrap-around, and scrolling can be paused. It sits between the board clock and the matrix connector and replaces fixed-pattern, fixed-direction matrix scrollers.

## Interface
- ROWS, 8: rows per displayed window; power of 2, ≥2.
- COLS, 8: columns per row, equal to the `segout` width. Bit value 1 = LED off.
- DEPTH, 16: pattern buffer rows; power of 2, ≥ ROWS.
- SCAN_DIV, 8192: clocks each row stays selected; ≥2.
- STEP_DIV, 25000000: enabled clocks per scroll step; ≥2.
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  1 = scroll timer runs; 0 = scrolling paused. Scanning always runs.
- dir  in  1  0 = offset increments per step; 1 = offset decrements.
- wr_en  in  1  pattern-buffer write strobe.
- wr_addr  in  clog2(DEPTH)  buffer row written.
- wr_data  in  COLS  row data written.
- segout  out  COLS  column data of the currently selected row.
- scanout  out  clog2(ROWS)  currently selected row.
- offset  out  clog2(DEPTH)  buffer row shown on window row 0.
- step_tick  out  1  one-cycle pulse in the cycle offset changes.

## Operation
- Reset (async, while high):
  - every buffer row = all ones (blank);
  - segout = all ones; scanout = 0; offset = 0; step_tick = 0;
  - scan and step counters = 0;
  - wr_en is ignored.
- Scan counter runs 0..SCAN_DIV-1. On wrap, scanout advances by 1 mod ROWS; ROWS-1 wraps to 0.
- Step counter runs only while en=1. On reaching STEP_DIV-1 it wraps to 0 and, in the same edge:
  - offset moves by +1 (dir=0) or -1 (dir=1) mod DEPTH: DEPTH-1→0 going up, 0→DEPTH-1 going down;
  - step_tick = 1 for that one cycle.
- en=0 freezes the step counter value, offset, and step_tick=0. The count resumes from the frozen value when en returns to 1.
- dir is sampled only on the step edge. Changing it mid-interval does not reset the step counter.
- segout is a register. At each edge it loads buf[(offset' + scanout') mod DEPTH], where the primed values are those being loaded at the same edge. This keeps segout, scanout and offset mutually consistent in every cycle, with no ghost cycle on row change.
- Buffer write: wr_en at edge k updates buf[wr_addr] at edge k. The segout load at edge k reads the pre-write data, so new data can first appear on segout after edge k+1.
- Index arithmetic is clog2(DEPTH) bits wide and wraps naturally; no overflow state.

## Timing
- Row dwell is exactly SCAN_DIV cycles. A full window refresh is ROWS×SCAN_DIV cycles.
- Step period is exactly STEP_DIV cycles of en=1, with no dead cycles between steps.
- Scan wrap and step wrap on the same edge are both applied; segout uses the new scanout and new offset.
- Reset deassertion: the first scan wrap occurs SCAN_DIV edges later, and the first step STEP_DIV enabled edges later.
- Reset asserted mid-operation overrides everything immediately, including the buffer contents.

## Test plan
All scenarios use ROWS=4, COLS=8, DEPTH=8, SCAN_DIV=4, STEP_DIV=10.
- Reset: assert reset asynchronously mid-cycle during scrolling → in that same cycle segout=8'hFF, scanout=0, offset=0, step_tick=0. After release, segout reads 8'hFF for all rows.
- Scan: write buf[i]=i for i=0..7, en=0 → scanout steps 0,1,2,3,0 every 4 cycles; segout shows 0,1,2,3 in lockstep; offset stays 0.
- Forward scroll: en=1, dir=0 → step_tick every 10 cycles; offset runs 1..7 then wraps to 0. With offset=6 and scanout=3, segout=8'h01.
- Reverse scroll: from offset=0, dir=1 → first step gives offset=7. With scanout=1, segout=8'h00.
- Pause: drop en at step count 6 for 25 cycles → offset unchanged, no step_tick. After en returns, the step occurs on the 4th enabled edge.
- Write hazard: wr_en with wr_addr=2, wr_data=8'hA5 while segout shows buf[2]=8'h02 → segout=8'h02 after the write edge; 8'hA5 appears after the next edge if row 2 is still selected.
